// File: rtl/vga_pkg.sv
// vga_pkg: shared raster constants, sprite motion mode encodings, button
// indices and the single-axis bounce/clamp step used by animated objects.
package vga_pkg;

   localparam int H_VIS     = 640;
   localparam int V_VIS     = 480;
   localparam int TICK_LINE = 481;

   typedef enum logic [1:0] {
      MODE_HOLD   = 2'b00,
      MODE_AUTO   = 2'b01,
      MODE_MANUAL = 2'b10
   } mode_e;

   // btn = {up, down, left, right}
   localparam int BTN_UP    = 3;
   localparam int BTN_DOWN  = 2;
   localparam int BTN_LEFT  = 1;
   localparam int BTN_RIGHT = 0;

   // One axis of sprite state; 11 bits so pos + step never wraps.
   typedef struct packed {
      logic [10:0] pos;
      logic        dir;   // 0 = increasing, 1 = decreasing
   } axis_t;

   // One frame step for a single axis. inc/dec are the manual buttons that
   // grow/shrink the coordinate. Compares happen before any subtraction so
   // nothing underflows; the final clamp pulls an over-range start back in.
   function automatic axis_t axis_next(axis_t cur, mode_e md, logic inc,
                                       logic dec, logic [10:0] lim,
                                       logic [10:0] step);
      axis_t nx;
      nx = cur;
      case (md)
         MODE_AUTO: begin
            if (!cur.dir) begin
               if (cur.pos + step >= lim) begin
                  nx.pos = lim;
                  nx.dir = 1'b1;
               end else begin
                  nx.pos = cur.pos + step;
               end
            end else begin
               if (cur.pos <= step) begin
                  nx.pos = '0;
                  nx.dir = 1'b0;
               end else begin
                  nx.pos = cur.pos - step;
               end
            end
         end
         MODE_MANUAL: begin
            if (inc && !dec)
               nx.pos = (cur.pos + step >= lim) ? lim : cur.pos + step;
            else if (dec && !inc)
               nx.pos = (cur.pos <= step) ? '0 : cur.pos - step;
         end
         default: ;
      endcase
      if (md != MODE_HOLD && nx.pos > lim)
         nx.pos = lim;
      return nx;
   endfunction

endpackage

// File: rtl/frame_tick_gen.sv
// frame_tick_gen: one-clk pulse per frame at (HCount == 0, VCount == TICK_LINE),
// edge-detected so a pixel held for several clk still yields one pulse.
// Ports: clk, reset (async high), HCount/VCount raster position, tick (comb).
module frame_tick_gen
   import vga_pkg::*;
#(
   parameter int TICK_V = TICK_LINE
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [9:0] HCount,
   input  logic [9:0] VCount,
   output logic       tick
);

   logic cond, cond_d;

   assign cond = (VCount == 10'(TICK_V)) && (HCount == '0);
   assign tick = cond & ~cond_d;

   // cond_d comes out of reset set, so a reset released while the tick pixel
   // is still being held cannot fire a late tick for that frame.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) cond_d <= 1'b1;
      else       cond_d <= cond;
   end

endmodule

// File: rtl/object_motion_ctrl.sv
// object_motion_ctrl: per-frame sprite origin sequencer (HOLD / AUTO bounce /
// MANUAL buttons). Updates only on the vertical-blanking tick.
// Ports: clk, reset (async high), HCount/VCount raster, run/manual/btn async
// levels; obj_x_l/obj_y_t origin, dir_x/dir_y bounce dirs, mode, frame_tick.
module object_motion_ctrl
   import vga_pkg::*;
#(
   parameter int OBJ_W  = 200,
   parameter int OBJ_H  = 150,
   parameter int X_INIT = 430,
   parameter int Y_INIT = 5,
   parameter int STEP   = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [9:0] HCount,
   input  logic [9:0] VCount,
   input  logic       run,
   input  logic       manual,
   input  logic [3:0] btn,
   output logic [9:0] obj_x_l,
   output logic [9:0] obj_y_t,
   output logic       dir_x,
   output logic       dir_y,
   output logic [1:0] mode,
   output logic       frame_tick
);

   localparam logic [10:0] XMAX  = 11'(H_VIS - OBJ_W);
   localparam logic [10:0] YMAX  = 11'(V_VIS - OBJ_H);
   localparam logic [10:0] STEPW = 11'(STEP);

   // {run, manual, btn} through a 2-flop synchroniser
   logic [5:0] sync1, sync2;
   logic       run_s, manual_s;
   logic [3:0] btn_s;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1 <= '0;
         sync2 <= '0;
      end else begin
         sync1 <= {run, manual, btn};
         sync2 <= sync1;
      end
   end

   assign {run_s, manual_s, btn_s} = sync2;

   logic tick;

   frame_tick_gen #(.TICK_V(TICK_LINE)) u_tick (
      .clk    (clk),
      .reset  (reset),
      .HCount (HCount),
      .VCount (VCount),
      .tick   (tick)
   );

   mode_e mode_q, mode_d;
   axis_t ax_q, ax_d, ay_q, ay_d;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mode_q     <= MODE_HOLD;
         ax_q       <= '{pos: 11'(X_INIT), dir: 1'b0};
         ay_q       <= '{pos: 11'(Y_INIT), dir: 1'b0};
         frame_tick <= 1'b0;
      end else begin
         mode_q     <= mode_d;
         ax_q       <= ax_d;
         ay_q       <= ay_d;
         frame_tick <= tick;
      end
   end

   // Movement uses the mode held before the tick; the new mode is latched
   // at the same edge and takes effect from the following frame.
   always_comb begin
      mode_d = mode_q;
      ax_d   = ax_q;
      ay_d   = ay_q;
      if (tick) begin
         ax_d = axis_next(ax_q, mode_q, btn_s[BTN_RIGHT], btn_s[BTN_LEFT], XMAX, STEPW);
         ay_d = axis_next(ay_q, mode_q, btn_s[BTN_DOWN], btn_s[BTN_UP], YMAX, STEPW);
         if (!run_s)       mode_d = MODE_HOLD;
         else if (manual_s) mode_d = MODE_MANUAL;
         else               mode_d = MODE_AUTO;
      end
   end

   assign obj_x_l = ax_q.pos[9:0];
   assign obj_y_t = ay_q.pos[9:0];
   assign dir_x   = ax_q.dir;
   assign dir_y   = ay_q.dir;
   assign mode    = mode_q;

endmodule

// File: doc/object_motion_ctrl.md
Name: object_motion_ctrl

Overview:
- Sequences the position of a bitmap sprite (default 200x150 triangle) on the 640x480 VGA raster.
- Produces the registered top-left origin (obj_x_l, obj_y_t) that the sprite renderer's window compare and ROM row/column address subtraction consume in place of fixed constants.
- Position changes only once per frame, during vertical blanking, so no tearing.
- Supports frozen (HOLD), bouncing (AUTO) and button-driven (MANUAL) modes.

Parameters:
- OBJ_W, 200, sprite width in pixels
- OBJ_H, 150, sprite height in pixels
- H_VIS, 640, visible columns
- V_VIS, 480, visible lines
- X_INIT, 430, reset value of obj_x_l
- Y_INIT, 5, reset value of obj_y_t
- STEP, 2, pixels moved per frame per axis (1..15)
- TICK_LINE, 481, VCount value (in blanking) at which the frame update occurs

Ports:
- clk  in  1  system clock (HCount/VCount may hold for several clk cycles per pixel)
- reset  in  1  asynchronous, active-high reset
- HCount  in  10  raster column from the sync generator
- VCount  in  10  raster line from the sync generator
- run  in  1  async level: 1 = motion enabled
- manual  in  1  async level: 1 = MANUAL mode, 0 = AUTO
- btn  in  4  async levels {up,down,left,right}, used in MANUAL only
- obj_x_l  out  10  sprite left column
- obj_y_t  out  10  sprite top line
- dir_x  out  1  AUTO horizontal direction: 0 = right, 1 = left
- dir_y  out  1  AUTO vertical direction: 0 = down, 1 = up
- mode  out  2  current state: 00 HOLD, 01 AUTO, 10 MANUAL
- frame_tick  out  1  one-clk pulse marking each position update

Behaviour:
- **Reset** (async, immediate): obj_x_l = X_INIT, obj_y_t = Y_INIT, dir_x = 0, dir_y = 0, mode = HOLD, frame_tick = 0, synchroniser flops cleared. Reset mid-frame discards any pending update.
- **Input sync:** run, manual and btn each pass through a 2-flop synchroniser. Only synchronised values are used, so input-to-effect latency is at least 2 clk plus the wait to the next tick.
- **Tick detect:**
  - cond = (VCount == TICK_LINE) && (HCount == 0); cond_d is cond registered.
  - The tick cycle is cond & ~cond_d, so there is exactly one tick per frame however long the pixel is held.
  - frame_tick, position, dir and mode registers all update on the clock edge ending the tick cycle, so they are visible together one cycle later.
  - No register changes in any other cycle.
- **Limits:** XMAX = H_VIS - OBJ_W (440), YMAX = V_VIS - OBJ_H (330). Arithmetic is 11-bit unsigned; compare before subtracting so nothing underflows. Position is always kept within 0..XMAX and 0..YMAX.
- **Update rule:** the update at a tick uses the mode held before the tick. The next mode is computed at the same tick:
  - run = 0 → HOLD
  - run = 1 and manual = 0 → AUTO
  - run = 1 and manual = 1 → MANUAL
- **HOLD:** position and dir are unchanged.
- **AUTO, x axis (y axis is analogous with YMAX and dir_y):**
  - dir_x = 0: if x + STEP >= XMAX, then x = XMAX and dir_x = 1; else x = x + STEP.
  - dir_x = 1: if x <= STEP, then x = 0 and dir_x = 0; else x = x - STEP.
  - The x and y axes update independently in the same tick, so corner hits flip both dirs.
- **MANUAL:**
  - right only: x = min(x + STEP, XMAX). left only: x = max(x - STEP, 0). Both or neither: x unchanged.
  - y is analogous using down/up with YMAX.
  - dir bits are frozen.
- **Mode transitions:**
  - MANUAL → AUTO resumes with the stored dir.
  - HOLD → AUTO resumes from the frozen position.
  - Mode changes between ticks have no effect until the next tick.
- **Out-of-range restore:** an out-of-range position is impossible by construction. If X_INIT > XMAX, the first AUTO or MANUAL tick clamps x to XMAX.

Decomposition:
- Package vga_pkg holds:
  - constants H_VIS, V_VIS, TICK_LINE
  - mode encodings MODE_HOLD, MODE_AUTO, MODE_MANUAL
  - button index constants BTN_UP/DOWN/LEFT/RIGHT
- Sub-module frame_tick_gen (HCount, VCount → one-clk tick pulse, edge-detected). Reusable by other animated objects.
- The per-axis bounce/clamp logic is written once and applied to x and y, parameterised by limit.

Test Plan:
1. Reset asserted while run = 1 → outputs immediately read 430/5, dir 0/0, mode 00. After release with run = 0 for 3 frames → unchanged, one frame_tick pulse per frame exactly 1 clk wide, with HCount held 2 clk per pixel.
2. run = 1, manual = 0 from reset →
   - first tick: mode becomes 01, position still 430/5 (HOLD was the prior mode)
   - ticks 2–6: x = 432, 434, 436, 438, 440 with dir_x flipping to 1 at 440
   - tick 7: x = 438
   - y runs 7, 9, 11, … in step.
3. AUTO with y driven near the bottom (e.g. 329, dir_y = 0) → next tick y = 330, dir_y = 1. Then 328. Top: y = 1, dir_y = 1 → y = 0, dir_y = 0.
4. MANUAL at x = 1 with left held → x = 0, then stays 0. Left+right held → x unchanged. Down held at y = 329 → 330, then stays 330. dir bits never change.
5. run dropped mid-frame (AUTO, x = 436) → next tick still moves to 438 and mode becomes HOLD. Following ticks hold 438. run re-asserted → resumes 440 with bounce.
6. Reset pulsed for 1 clk mid-frame in AUTO at x = 438 → immediately 430/5/HOLD. The frame_tick pulse pending in that frame must not cause an update if reset overlaps the tick cycle.
